// File: rtl/demux_1x2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with one registered single-entry slot per channel.
// Optional macro DEMUX_COUNT_EN adds 8-bit completed-transfer counters cnt0/cnt1.
//
// Slot FSM (one instance per channel)
//   state      | meaning
//   SLOT_EMPTY | no word held, yN_valid=0
//   SLOT_FULL  | word held in yN, yN_valid=1 until the downstream takes it

module demux_1x2_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    input  logic             y0_ready,
    input  logic             y1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e            slot0_q, slot0_d;
    slot_e            slot1_q, slot1_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;

    logic sel_full;
    logic sel_ready;
    logic accept;
    logic load0, load1;
    logic xfer0, xfer1;

    // Head-of-line blocking: only the selected slot decides in_ready.
    always_comb begin
        sel_full  = 1'b0;
        sel_ready = 1'b0;
        if (s) begin
            sel_full  = (slot1_q == SLOT_FULL);
            sel_ready = y1_ready;
        end else begin
            sel_full  = (slot0_q == SLOT_FULL);
            sel_ready = y0_ready;
        end
    end

    assign in_ready = !sel_full || sel_ready;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !s;
    assign load1    = accept && s;
    assign xfer0    = (slot0_q == SLOT_FULL) && y0_ready;
    assign xfer1    = (slot1_q == SLOT_FULL) && y1_ready;

    always_comb begin
        slot0_d = slot0_q;
        y0_d    = y0_q;
        case (slot0_q)
            SLOT_EMPTY: begin
                if (load0) begin
                    slot0_d = SLOT_FULL;
                    y0_d    = d;
                end
            end
            SLOT_FULL: begin
                // A load in the same cycle as a transfer refills without a bubble.
                if (load0) begin
                    y0_d = d;
                end else if (xfer0) begin
                    slot0_d = SLOT_EMPTY;
                end
            end
            default: slot0_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        slot1_d = slot1_q;
        y1_d    = y1_q;
        case (slot1_q)
            SLOT_EMPTY: begin
                if (load1) begin
                    slot1_d = SLOT_FULL;
                    y1_d    = d;
                end
            end
            SLOT_FULL: begin
                if (load1) begin
                    y1_d = d;
                end else if (xfer1) begin
                    slot1_d = SLOT_EMPTY;
                end
            end
            default: slot1_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= SLOT_EMPTY;
            slot1_q <= SLOT_EMPTY;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    assign y0       = y0_q;
    assign y1       = y1_q;
    assign y0_valid = (slot0_q == SLOT_FULL);
    assign y1_valid = (slot1_q == SLOT_FULL);

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (xfer0) cnt0_d = cnt0_q + 8'd1;
        if (xfer1) cnt1_d = cnt1_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Counters not built; transfer strobes only drive the slot FSMs.
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Self-checking bench for demux_1x2_stream: directed scenarios plus random traffic
// compared against a per-channel queue model of the stream behaviour.

module tb_demux_1x2_stream;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d;
    logic             s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0, y1;
    logic             y0_valid, y1_valid;
    logic             y0_ready, y1_ready;
`ifdef DEMUX_COUNT_EN
    logic [7:0]       cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a queue of words awaiting transfer.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    logic [WIDTH-1:0] last0, last1;
    int               xfers0, xfers1;

    demux_1x2_stream #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid),
        .y0_ready (y0_ready),
        .y1_ready (y1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_in_ready();
        if (s) return (mq1.size() == 0) || y1_ready;
        return (mq0.size() == 0) || y0_ready;
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        last0  = '0;
        last1  = '0;
        xfers0 = 0;
        xfers1 = 0;
    endtask

    // Advance model by one rising edge using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit acc;
        acc = in_valid && model_in_ready();
        if (mq0.size() > 0 && y0_ready) begin
            void'(mq0.pop_front());
            xfers0++;
        end
        if (mq1.size() > 0 && y1_ready) begin
            void'(mq1.pop_front());
            xfers1++;
        end
        if (acc) begin
            if (s) begin
                mq1.push_back(d);
                last1 = d;
            end else begin
                mq0.push_back(d);
                last0 = d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit sel, input logic [WIDTH-1:0] data,
                         input bit r0, input bit r1);
        in_valid = v;
        s        = sel;
        d        = data;
        y0_ready = r0;
        y1_ready = r1;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        #3;
        n_checks++;
        if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got y0_valid=%b y1_valid=%b want 0 0", y0_valid, y1_valid);
        end
        n_checks++;
        if (y0 !== 8'h00 || y1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got y0=%h y1=%h want 00 00", y0, y1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_s0: got %b want 1", in_ready);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_s1: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (y0_valid !== 1'b1 || y0 !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_y0: got valid=%b y0=%h want 1 a5", y0_valid, y0);
        end
        n_checks++;
        if (y1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_y1_valid: got %b want 0", y1_valid);
        end
        tick();
        n_checks++;
        if (y0_valid !== 1'b0 || y0 !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_drained: got valid=%b y0=%h want 0 a5", y0_valid, y0);
        end
        drain();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (y1_valid !== 1'b1 || y1 !== 8'h3C) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got valid=%b y1=%h want 1 3c", i, y1_valid, y1);
            end
        end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready_blocked: got %b want 0", in_ready);
        end
        tick();
        n_checks++;
        if (y1 !== 8'h3C || y1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_not_accepted: got valid=%b y1=%h want 1 3c", y1_valid, y1);
        end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_in_ready_release: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        n_checks++;
        if (y1 !== 8'h77 || y1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_next_word: got valid=%b y1=%h want 1 77", y1_valid, y1);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (y1_valid !== 1'b0 || y1 !== 8'h77) begin
            n_fail++;
            $display("FAIL stall_drained: got valid=%b y1=%h want 0 77", y1_valid, y1);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (y0 !== 8'h11 || y0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_replace: got valid=%b y0=%h want 1 11", y0_valid, y0);
        end
        drain();
    endtask

    task automatic test_hol_blocking();
        drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_other_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        n_checks++;
        if (y1 !== 8'h22 || y1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_y1_loaded: got valid=%b y1=%h want 1 22", y1_valid, y1);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hol_blocked_%0d: got %b want 0", i, in_ready);
            end
            tick();
        end
        n_checks++;
        if (y0 !== 8'h44 || y0_valid !== 1'b1 || y1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hol_held: got y0=%h v0=%b v1=%b want 44 1 0", y0, y0_valid, y1_valid);
        end
        drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_unblocked: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (y0 !== 8'h33 || y0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_y0_next: got valid=%b y0=%h want 1 33", y0_valid, y0);
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (y0_valid !== 1'b1 || y1_valid !== 1'b1 || y0 !== 8'hAA || y1 !== 8'hBB) begin
            n_fail++;
            $display("FAIL areset_full: got v0=%b v1=%b y0=%h y1=%h want 1 1 aa bb",
                     y0_valid, y1_valid, y0, y1);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (y0_valid !== 1'b0 || y1_valid !== 1'b0 || y0 !== 8'h00 || y1 !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_clear: got v0=%b v1=%b y0=%h y1=%h want 0 0 00 00",
                     y0_valid, y1_valid, y0, y1);
        end
        drive(1'b1, 1'b0, 8'hCC, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (y0_valid !== 1'b0 || y0 !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_no_load: got v0=%b y0=%h want 0 00", y0_valid, y0);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            exp_rdy = model_in_ready();
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy);
            end
            n_checks++;
            if (y0_valid !== (mq0.size() != 0) || y0 !== last0) begin
                n_fail++;
                $display("FAIL rand_y0 cyc %0d: got v=%b y0=%h want v=%b y0=%h",
                         i, y0_valid, y0, (mq0.size() != 0), last0);
            end
            n_checks++;
            if (y1_valid !== (mq1.size() != 0) || y1 !== last1) begin
                n_fail++;
                $display("FAIL rand_y1 cyc %0d: got v=%b y1=%h want v=%b y1=%h",
                         i, y1_valid, y1, (mq1.size() != 0), last1);
            end
            tick();
        end
        drain();
    endtask

`ifdef DEMUX_COUNT_EN
    task automatic test_counter();
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (xfers0 != 257 || cnt0 !== 8'd1) begin
            n_fail++;
            $display("FAIL cnt0_wrap: got %0d want 1 (model transfers %0d)", cnt0, xfers0);
        end
        n_checks++;
        if (cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt1_idle: got %0d want 0", cnt1);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        s        = 1'b0;
        d        = '0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_hol_blocking();
        test_async_reset();
        test_random();
`ifdef DEMUX_COUNT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
